// File: rtl/alu_logic_pkg.sv
// Shared opcode encodings and the per-bit logic function for the ALU logic pipe.
package alu_logic_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOTA  = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_XNOR  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Every opcode is bitwise, so the result is built one bit at a time by the caller.
    function automatic logic alu_logic_bit(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOTA: r = ~a;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = b; // OP_PASSB
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_logic_fifo.sv
// Result buffer for alu_logic_pipe: DEPTH-entry FIFO with valid/ready on both sides.
// in_ready depends only on occupancy, never on the same-cycle pop.
module alu_logic_fifo
    import alu_logic_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign in_ready  = (count_q < DepthC);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because out_valid gates their use.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/alu_logic_pipe.sv
// Bitwise logic unit with accumulator and a buffered valid/ready result stream.
// Optional feature macro: ALU_LOGIC_FLAGS_EN adds registered zero/parity outputs
// stored alongside each result.
module alu_logic_pipe
    import alu_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       S,
    input  logic             acc_sel,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] OUT,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ALU_LOGIC_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

`ifdef ALU_LOGIC_FLAGS_EN
    localparam int unsigned FW = 2;
`else
    localparam int unsigned FW = 0;
`endif
    localparam int unsigned DW = WIDTH + FW;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic [DW-1:0]    wr_data;
    logic [DW-1:0]    head;
    logic             push;

    assign push = in_valid & in_ready;

    // Datapath: select operand A, then apply the opcode bit by bit.
    always_comb begin
        op_a   = acc_sel ? acc_q : A;
        result = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            result[i] = alu_logic_bit(S, op_a[i], B[i]);
        end
    end

`ifdef ALU_LOGIC_FLAGS_EN
    assign wr_data = {(result == '0), ^result, result};
`else
    assign wr_data = result;
`endif

    // Accumulator next-state: clear wins over the same-cycle update.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr)   acc_d = '0;
        else if (push) acc_d = result;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    alu_logic_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    // Output gating keeps OUT and flags at their idle values whenever the buffer is empty.
    always_comb begin
        OUT = out_valid ? head[WIDTH-1:0] : '0;
`ifdef ALU_LOGIC_FLAGS_EN
        zero   = out_valid ? head[WIDTH+1] : 1'b1;
        parity = out_valid ? head[WIDTH]   : 1'b0;
`endif
    end

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Scoreboard bench for alu_logic_pipe (WIDTH=8, DEPTH=2) with directed vectors.
module tb_alu_logic_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] s = '0;
    logic       acc_sel = 1'b0;
    logic       acc_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef ALU_LOGIC_FLAGS_EN
    logic       zero;
    logic       parity;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] data;
        logic       z;
        logic       p;
        bit         chk;
        int         acyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    alu_logic_pipe #(
        .WIDTH (8),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .S         (s),
        .acc_sel   (acc_sel),
        .acc_clr   (acc_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OUT       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ALU_LOGIC_FLAGS_EN
        ,
        .zero      (zero),
        .parity    (parity)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h expected no output", out);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_data", 64'(out), 64'(mon_e.data));
`ifdef ALU_LOGIC_FLAGS_EN
                check("zero_flag", 64'(zero), 64'(mon_e.z));
                check("parity_flag", 64'(parity), 64'(mon_e.p));
`endif
                if (mon_e.chk) check("latency", 64'(cyc), 64'(mon_e.acyc + 1));
            end
        end
    end

    // Drive one request and hold it until accepted; returns one cycle after acceptance.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] ts,
                        input logic sel, input logic clr, input logic [7:0] exp, input bit chk);
        int   n;
        exp_t e;
        a        = ta;
        b        = tb;
        s        = ts;
        acc_sel  = sel;
        acc_clr  = clr;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            e.data = exp;
            e.z    = (exp == 8'h00);
            e.p    = ^exp;
            e.chk  = chk;
            e.acyc = cyc;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        acc_sel  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out", 64'(out), 64'd0);
`ifdef ALU_LOGIC_FLAGS_EN
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_parity", 64'(parity), 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back opcodes, one-cycle latency
        out_ready = 1'b1;
        send(8'hF0, 8'h3C, 3'b000, 1'b0, 1'b0, 8'h30, 1'b1);
        send(8'hF0, 8'h3C, 3'b001, 1'b0, 1'b0, 8'hFC, 1'b1);
        send(8'hF0, 8'h3C, 3'b010, 1'b0, 1'b0, 8'hCC, 1'b1);
        send(8'hF0, 8'h3C, 3'b011, 1'b0, 1'b0, 8'h0F, 1'b1);
        wait_drain();

        // Accumulator chain after clear
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        send(8'h00, 8'h0F, 3'b111, 1'b1, 1'b0, 8'h0F, 1'b0);
        send(8'h00, 8'h0F, 3'b011, 1'b1, 1'b0, 8'hF0, 1'b0);

        // Clear concurrent with acc_sel transfer uses pre-clear acc, then acc is 0
        send(8'h00, 8'h55, 3'b111, 1'b0, 1'b0, 8'h55, 1'b0);
        send(8'h00, 8'hFF, 3'b010, 1'b1, 1'b1, 8'hAA, 1'b0);
        send(8'h77, 8'hFF, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        wait_drain();

        // Backpressure: fill, stall, release
        out_ready = 1'b0;
        send(8'h11, 8'h22, 3'b001, 1'b0, 1'b0, 8'h33, 1'b0);
        check("in_ready_one", 64'(in_ready), 64'd1);
        send(8'h0F, 8'hFF, 3'b100, 1'b0, 1'b0, 8'hF0, 1'b0);
        check("in_ready_full", 64'(in_ready), 64'd0);
        fork
            send(8'h0F, 8'h33, 3'b110, 1'b0, 1'b0, 8'hC3, 1'b0);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_hold", 64'(out), 64'h33);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        join
        send(8'hA5, 8'h5A, 3'b101, 1'b0, 1'b0, 8'h00, 1'b0);
        wait_drain();

        // Reset with two results buffered
        out_ready = 1'b0;
        send(8'h01, 8'h02, 3'b001, 1'b0, 1'b0, 8'h03, 1'b0);
        send(8'h04, 8'h08, 3'b001, 1'b0, 1'b0, 8'h0C, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out", 64'(out), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h3C, 8'hF0, 3'b000, 1'b0, 1'b0, 8'h30, 1'b1);
        wait_drain();

        // Flag vectors (flags compared when the feature is built)
        send(8'h5A, 8'h5A, 3'b010, 1'b0, 1'b0, 8'h00, 1'b1);
        send(8'h01, 8'h00, 3'b001, 1'b0, 1'b0, 8'h01, 1'b1);
        wait_drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
